// File: rtl/cospike_trace_arbiter_if.sv
// Output channel from the trace arbiter to the cosim checker wrapper.
// The arbiter drives the record; the checker drives out_ready.
interface cospike_trace_arbiter_if #(
  parameter int unsigned TW = 231
);
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_hartid;
  logic [63:0]   out_cycle;
  logic [TW-1:0] out_trace;

  modport master (
    output out_valid,
    output out_hartid,
    output out_cycle,
    output out_trace,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_hartid,
    input  out_cycle,
    input  out_trace,
    output out_ready
  );
endinterface

// File: rtl/cospike_trace_arbiter.sv
// Per-hart buffering of two-lane retire traces, timestamped at capture and
// serialized round-robin onto a single registered valid/ready channel.
module cospike_trace_arbiter #(
  parameter  int unsigned NHARTS       = 1,
  parameter  int unsigned DEPTH        = 16,
  parameter  int unsigned STALL_THRESH = DEPTH - 4,
  localparam int unsigned TW           = 231
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NHARTS*2*TW-1:0]   trace_in,
  output logic [NHARTS-1:0]        hart_stall,
  output logic [NHARTS-1:0]        overflow,
  cospike_trace_arbiter_if.master  out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
  localparam int unsigned EW = TW + 64;

  function automatic logic qualifies(input logic [TW-1:0] r);
    return r[0] | r[97] | (r[162:99] != '0);
  endfunction

  logic [63:0]       cycle;
  logic [HW-1:0]     rr;
  logic [HW-1:0]     rr_nxt;
  logic [HW-1:0]     win;
  logic              any;
  logic              load;
  logic [NHARTS-1:0] pop;
  logic [NHARTS-1:0] nonempty;
  logic [EW-1:0]     head [NHARTS];
  int unsigned       idx;

  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    logic [TW-1:0] lane0;
    logic [TW-1:0] lane1;
    logic          q0;
    logic          q1;
    logic [1:0]    n_want;
    logic [1:0]    n_acc;
    logic [CW-1:0] free;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [TW-1:0] wr_a;
    logic [TW-1:0] wr_b;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          stall_r;
    logic          ovf_r;
    logic [EW-1:0] mem [DEPTH];

    assign lane0 = trace_in[(2*h)*TW +: TW];
    assign lane1 = trace_in[(2*h+1)*TW +: TW];
    assign q0    = qualifies(lane0);
    assign q1    = qualifies(lane1);

    // Lane 0 always takes the first slot; a lone lane 1 slides into it.
    // Space freed by this cycle's pop is usable by this cycle's pushes.
    always_comb begin
      n_want  = {1'b0, q0} + {1'b0, q1};
      wr_a    = q0 ? lane0 : lane1;
      wr_b    = lane1;
      free    = CW'(DEPTH) - cnt + CW'(pop[h]);
      n_acc   = n_want;
      if (CW'(n_want) > free) begin
        n_acc = free[1:0];
      end
      cnt_nxt = cnt + CW'(n_acc) - CW'(pop[h]);
    end

    always_ff @(posedge clock) begin
      if (n_acc != 2'd0) begin
        mem[wptr] <= {cycle, wr_a};
      end
      if (n_acc == 2'd2) begin
        mem[wptr + 1'b1] <= {cycle, wr_b};
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wptr    <= '0;
        rptr    <= '0;
        cnt     <= '0;
        stall_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else begin
        wptr    <= wptr + AW'(n_acc);
        if (pop[h]) begin
          rptr <= rptr + 1'b1;
        end
        cnt     <= cnt_nxt;
        stall_r <= (cnt_nxt >= CW'(STALL_THRESH));
        if (n_acc != n_want) begin
          ovf_r <= 1'b1;
        end
      end
    end

    assign nonempty[h]   = (cnt != '0);
    assign head[h]       = mem[rptr];
    assign hart_stall[h] = stall_r;
    assign overflow[h]   = ovf_r;
  end

  // Arbitration looks only at registered occupancy, so a record pushed this
  // cycle can never reach the output in the same cycle.
  always_comb begin
    load   = !out.out_valid || out.out_ready;
    any    = 1'b0;
    win    = '0;
    pop    = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NHARTS; i++) begin
      idx = (32'(rr) + i) % NHARTS;
      if (!any && nonempty[HW'(idx)]) begin
        any = 1'b1;
        win = HW'(idx);
      end
    end
    if (load && any) begin
      pop[win] = 1'b1;
    end
    rr_nxt = HW'((32'(win) + 32'd1) % NHARTS);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle          <= '0;
      rr             <= '0;
      out.out_valid  <= 1'b0;
      out.out_hartid <= '0;
      out.out_cycle  <= '0;
      out.out_trace  <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (load) begin
        out.out_valid <= any;
        if (any) begin
          out.out_hartid               <= 64'(win);
          {out.out_cycle, out.out_trace} <= head[win];
          rr                           <= rr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_cospike_trace_arbiter.sv
// Directed bench for cospike_trace_arbiter (two harts, depth 16) with an
// expected-record queue drained by an independent output monitor.
module tb_cospike_trace_arbiter;
  localparam int unsigned NH = 2;
  localparam int unsigned TW = 231;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NH*2*TW-1:0] trace_in;
  logic [NH-1:0]     hart_stall;
  logic [NH-1:0]     overflow;

  cospike_trace_arbiter_if #(.TW(TW)) bus ();

  cospike_trace_arbiter #(
    .NHARTS(NH),
    .DEPTH(16),
    .STALL_THRESH(12)
  ) dut (
    .clock(clock),
    .reset(reset),
    .trace_in(trace_in),
    .hart_stall(hart_stall),
    .overflow(overflow),
    .out(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0]   hart;
    logic [63:0]   cyc;
    logic [TW-1:0] tr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] tb_cycle;

  // Clock edges seen since reset release; equals the timestamp a lane driven
  // now will be stamped with at the next rising edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_cycle <= '0;
    else        tb_cycle <= tb_cycle + 64'd1;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [TW-1:0] mk(input logic v, input logic [63:0] pc,
                                        input logic exc, input logic [63:0] cause);
    logic [TW-1:0] r;
    r           = '0;
    r[0]        = v;
    r[64:1]     = pc;
    r[96:65]    = pc[31:0] ^ 32'h0000_0013;
    r[97]       = exc;
    r[162:99]   = cause;
    r[163]      = v;
    r[227:164]  = ~pc;
    r[230:228]  = 3'd3;
    return r;
  endfunction

  task automatic set_lane(input int h, input int l, input logic [TW-1:0] r);
    trace_in[(2*h+l)*TW +: TW] = r;
  endtask

  task automatic expect_rec(input int h, input logic [63:0] ts, input logic [TW-1:0] r);
    exp_t x;
    x.hart = 64'(h);
    x.cyc  = ts;
    x.tr   = r;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(negedge clock);
    trace_in = '0;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    trace_in      = '0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk(name, 512'(exp_q.size()), 512'd0);
  endtask

  task automatic fill15(input logic [63:0] base);
    logic [TW-1:0] r0;
    logic [TW-1:0] r1;
    for (int k = 1; k <= 9; k++) begin
      r0 = mk(1'b1, base + 64'(k*16), 1'b0, 64'd0);
      r1 = mk(1'b1, base + 64'(k*16 + 4), 1'b0, 64'd0);
      set_lane(0, 0, r0);
      expect_rec(0, tb_cycle, r0);
      if (k >= 2 && k <= 8) begin
        set_lane(0, 1, r1);
        expect_rec(0, tb_cycle, r1);
      end
      step();
    end
  endtask

  // Output monitor: every accepted record must match the queue head; a record
  // held under backpressure must not change.
  logic          hold = 1'b0;
  logic [63:0]   h_hart;
  logic [63:0]   h_cyc;
  logic [TW-1:0] h_tr;

  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stable_valid", 512'(bus.out_valid), 512'd1);
        chk("stable_record", {bus.out_hartid, bus.out_cycle, bus.out_trace},
            {h_hart, h_cyc, h_tr});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record actual hart=%0d cycle=%0d required=none",
                   bus.out_hartid, bus.out_cycle);
        end else begin
          e = exp_q.pop_front();
          chk("rec_hart", 512'(bus.out_hartid), 512'(e.hart));
          chk("rec_cycle", 512'(bus.out_cycle), 512'(e.cyc));
          chk("rec_trace", 512'(bus.out_trace), 512'(e.tr));
        end
      end
      hold   = bus.out_valid && !bus.out_ready;
      h_hart = bus.out_hartid;
      h_cyc  = bus.out_cycle;
      h_tr   = bus.out_trace;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] ra [6];
    logic [63:0]   ts [3];
    logic [TW-1:0] r0;
    logic [TW-1:0] r1;

    trace_in      = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;

    // Reset state
    @(negedge clock);
    #1;
    chk("rst_valid", 512'(bus.out_valid), 512'd0);
    chk("rst_hartid", 512'(bus.out_hartid), 512'd0);
    chk("rst_cycle", 512'(bus.out_cycle), 512'd0);
    chk("rst_trace", 512'(bus.out_trace), 512'd0);
    chk("rst_stall", 512'(hart_stall), 512'd0);
    chk("rst_overflow", 512'(overflow), 512'd0);
    @(negedge clock);
    reset = 1'b1;

    // Both lanes in one cycle: lane 0 first, equal stamps, one-cycle latency
    bus.out_ready = 1'b1;
    r0 = mk(1'b1, 64'h0000_0000_8000_0000, 1'b0, 64'd0);
    r1 = mk(1'b1, 64'h0000_0000_8000_0004, 1'b0, 64'd0);
    set_lane(0, 0, r0);
    set_lane(0, 1, r1);
    expect_rec(0, tb_cycle, r0);
    expect_rec(0, tb_cycle, r1);
    step();
    chk("lat_capture_edge", 512'(bus.out_valid), 512'd0);
    step();
    chk("lat_next_edge", 512'(bus.out_valid), 512'd1);
    step();
    chk("second_consecutive", 512'(bus.out_valid), 512'd1);
    wait_drain("drain_pair", 20);
    chk("idle_after_pair", 512'(bus.out_valid), 512'd0);

    // Qualification: non-qualifying lane 0, exception-only lane 1
    r0 = mk(1'b0, 64'h0000_0000_8000_0010, 1'b0, 64'd0);
    r1 = mk(1'b0, 64'h0000_0000_8000_0014, 1'b1, 64'd2);
    set_lane(0, 0, r0);
    set_lane(0, 1, r1);
    expect_rec(0, tb_cycle, r1);
    step();
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 0, r0);
      set_lane(1, 1, mk(1'b0, 64'h0000_0000_9000_0000, 1'b0, 64'd0));
      step();
    end
    wait_drain("drain_filter", 20);
    chk("idle_after_filter", 512'(bus.out_valid), 512'd0);

    // Two harts, three records each, released together: strict alternation
    do_reset();
    for (int c = 0; c < 3; c++) begin
      ra[2*c]   = mk(1'b1, 64'h0000_0000_8000_1000 + 64'(c*4), 1'b0, 64'd0);
      ra[2*c+1] = mk(1'b1, 64'h0000_0000_8001_1000 + 64'(c*4), 1'b0, 64'd0);
      set_lane(0, 0, ra[2*c]);
      set_lane(1, 0, ra[2*c+1]);
      ts[c] = tb_cycle;
      step();
    end
    for (int c = 0; c < 3; c++) begin
      expect_rec(0, ts[c], ra[2*c]);
      expect_rec(1, ts[c], ra[2*c+1]);
    end
    bus.out_ready = 1'b1;
    wait_drain("drain_rr", 30);

    // Only hart 1 active: back-to-back hart 1 records
    r0 = mk(1'b1, 64'h0000_0000_8002_0000, 1'b0, 64'd0);
    r1 = mk(1'b1, 64'h0000_0000_8002_0004, 1'b0, 64'd0);
    set_lane(1, 0, r0);
    set_lane(1, 1, r1);
    expect_rec(1, tb_cycle, r0);
    expect_rec(1, tb_cycle, r1);
    step();
    r0 = mk(1'b1, 64'h0000_0000_8002_0008, 1'b0, 64'd0);
    set_lane(1, 0, r0);
    expect_rec(1, tb_cycle, r0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("h1_consec_valid", 512'(bus.out_valid), 512'd1);
      chk("h1_consec_hart", 512'(bus.out_hartid), 512'd1);
      step();
    end
    wait_drain("drain_h1", 20);

    // Backpressure: 10 cycles of 2 lanes with the checker stalled
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      r0 = mk(1'b1, 64'h0000_0000_8003_0000 + 64'(k*8), 1'b0, 64'd0);
      r1 = mk(1'b1, 64'h0000_0000_8003_0004 + 64'(k*8), 1'b0, 64'd0);
      set_lane(0, 0, r0);
      set_lane(0, 1, r1);
      if (k <= 9) expect_rec(0, tb_cycle, r0);
      if (k <= 8) expect_rec(0, tb_cycle, r1);
      step();
      chk("bp_stall", 512'(hart_stall[0]), 512'(k >= 7));
      chk("bp_overflow", 512'(overflow[0]), 512'(k >= 9));
      chk("bp_valid", 512'(bus.out_valid), 512'(k >= 2));
    end
    chk("bp_queued", 512'(exp_q.size()), 512'd17);
    bus.out_ready = 1'b1;
    wait_drain("drain_bp", 60);
    chk("bp_stall_released", 512'(hart_stall[0]), 512'd0);
    chk("bp_overflow_sticky", 512'(overflow[0]), 512'd1);

    // Count 15, no pop: lane 1 dropped
    do_reset();
    fill15(64'h0000_0000_8004_0000);
    chk("pf_stall", 512'(hart_stall[0]), 512'd1);
    chk("pf_overflow_pre", 512'(overflow[0]), 512'd0);
    r0 = mk(1'b1, 64'h0000_0000_8004_1000, 1'b0, 64'd0);
    r1 = mk(1'b1, 64'h0000_0000_8004_1004, 1'b0, 64'd0);
    set_lane(0, 0, r0);
    set_lane(0, 1, r1);
    expect_rec(0, tb_cycle, r0);
    step();
    chk("pf_overflow", 512'(overflow[0]), 512'd1);
    bus.out_ready = 1'b1;
    wait_drain("drain_pf", 60);

    // Count 15 with a pop in the same cycle: both lanes fit
    do_reset();
    fill15(64'h0000_0000_8005_0000);
    r0 = mk(1'b1, 64'h0000_0000_8005_1000, 1'b0, 64'd0);
    r1 = mk(1'b1, 64'h0000_0000_8005_1004, 1'b0, 64'd0);
    set_lane(0, 0, r0);
    set_lane(0, 1, r1);
    expect_rec(0, tb_cycle, r0);
    expect_rec(0, tb_cycle, r1);
    bus.out_ready = 1'b1;
    step();
    chk("pfp_overflow", 512'(overflow[0]), 512'd0);
    wait_drain("drain_pfp", 60);
    chk("pfp_overflow_end", 512'(overflow[0]), 512'd0);

    // Asynchronous reset while a record is presented
    do_reset();
    set_lane(0, 0, mk(1'b1, 64'h0000_0000_8006_0000, 1'b0, 64'd0));
    set_lane(1, 0, mk(1'b1, 64'h0000_0000_8006_1000, 1'b0, 64'd0));
    step();
    step();
    chk("mid_valid", 512'(bus.out_valid), 512'd1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", 512'(bus.out_valid), 512'd0);
    chk("arst_hartid", 512'(bus.out_hartid), 512'd0);
    chk("arst_cycle", 512'(bus.out_cycle), 512'd0);
    chk("arst_trace", 512'(bus.out_trace), 512'd0);
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_stale", 512'(bus.out_valid), 512'd0);
    end
    r0 = mk(1'b1, 64'h0000_0000_8007_0000, 1'b0, 64'd0);
    set_lane(0, 0, r0);
    expect_rec(0, 64'd3, r0);
    step();
    wait_drain("drain_after_reset", 20);
    chk("final_idle", 512'(bus.out_valid), 512'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
